// File: rtl/qspi_sram_responder_if.sv
// rtl/qspi_sram_responder_if.sv - SIO pin group between the serial SRAM initiator and responder
interface qspi_sram_responder_if;
  logic sram_cs_n;
  logic sram_sck;
  logic sram_sio0_i;
  logic sram_sio1_i;
  logic sram_sio2_i;
  logic sram_sio3_i;
  logic sram_sio0_o;
  logic sram_sio1_o;
  logic sram_sio2_o;
  logic sram_sio3_o;
  logic sram_sio_oe;

  modport master (
    output sram_cs_n, sram_sck,
    output sram_sio0_i, sram_sio1_i, sram_sio2_i, sram_sio3_i,
    input  sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o,
    input  sram_sio_oe
  );

  modport slave (
    input  sram_cs_n, sram_sck,
    input  sram_sio0_i, sram_sio1_i, sram_sio2_i, sram_sio3_i,
    output sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o,
    output sram_sio_oe
  );
endinterface

// File: rtl/qspi_sram_responder.sv
// rtl/qspi_sram_responder.sv - byte-addressed QSPI SRAM model with SPI/SQI modes and quad read/write
module qspi_sram_responder #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  qspi_sram_responder_if.slave sram,
  output logic                 quad_mode
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SPI_CMD,
    QUAD_CMD,
    ADDR,
    DUMMY,
    WRITE,
    READ,
    SKIP
  } state_t;

  state_t state, state_n;

  logic                     sck_q;
  logic [7:0]               cnt, cnt_n;
  logic [19:0]              shreg, shreg_n;
  logic [ADDRESS_WIDTH-1:0] addr, addr_n;
  logic                     is_write, is_write_n;
  logic                     half, half_n;
  logic [3:0]               wr_hi, wr_hi_n;
  logic [7:0]               rd_byte, rd_byte_n;
  logic                     quad_n;
  logic                     sio_oe, sio_oe_n;
  logic [3:0]               sio_o, sio_o_n;

  logic                     mem_we;
  logic [7:0]               mem_wdata;
  logic [7:0]               mem [DEPTH];

  logic                     sck_rise, sck_fall;
  logic [3:0]               sio_in;
  logic [23:0]              shift_nib;
  logic [7:0]               shift_bit;
  logic [ADDRESS_WIDTH-1:0] addr_inc;
  logic                     unused_addr_hi;

  assign sck_rise  = sram.sram_sck & ~sck_q;
  assign sck_fall  = ~sram.sram_sck & sck_q;
  assign sio_in    = {sram.sram_sio3_i, sram.sram_sio2_i, sram.sram_sio1_i, sram.sram_sio0_i};
  assign shift_nib = {shreg, sio_in};
  assign shift_bit = {shreg[6:0], sram.sram_sio0_i};
  assign addr_inc  = addr + 1'b1;
  // Address bits above ADDRESS_WIDTH are deliberately dropped; this keeps them visibly consumed.
  assign unused_addr_hi = ^shift_nib;

  assign sram.sram_sio0_o = sio_o[0];
  assign sram.sram_sio1_o = sio_o[1];
  assign sram.sram_sio2_o = sio_o[2];
  assign sram.sram_sio3_o = sio_o[3];
  assign sram.sram_sio_oe = sio_oe;

  // Protocol state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state, datapath updates and memory write strobe for the current sck edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    addr_n     = addr;
    is_write_n = is_write;
    half_n     = half;
    wr_hi_n    = wr_hi;
    rd_byte_n  = rd_byte;
    quad_n     = quad_mode;
    sio_oe_n   = sio_oe;
    sio_o_n    = sio_o;
    mem_we     = 1'b0;
    mem_wdata  = {wr_hi, sio_in};

    if (sram.sram_cs_n) begin
      state_n  = IDLE;
      cnt_n    = 8'd0;
      half_n   = 1'b0;
      sio_oe_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The rise that opens the command already carries the first bit/nibble.
          if (sck_rise) begin
            cnt_n = 8'd1;
            if (quad_mode) begin
              shreg_n = shift_nib[19:0];
              state_n = QUAD_CMD;
            end else begin
              shreg_n = {shreg[18:0], sram.sram_sio0_i};
              state_n = SPI_CMD;
            end
          end
        end
        SPI_CMD: begin
          if (sck_rise) begin
            shreg_n = {shreg[18:0], sram.sram_sio0_i};
            cnt_n   = cnt + 8'd1;
            if (cnt == 8'd7) begin
              cnt_n   = 8'd0;
              state_n = SKIP;
              if (shift_bit == 8'h38) quad_n = 1'b1;
            end
          end
        end
        QUAD_CMD: begin
          if (sck_rise) begin
            shreg_n = shift_nib[19:0];
            cnt_n   = cnt + 8'd1;
            if (cnt == 8'd1) begin
              cnt_n = 8'd0;
              case (shift_nib[7:0])
                8'h02: begin is_write_n = 1'b1; state_n = ADDR; end
                8'h03: begin is_write_n = 1'b0; state_n = ADDR; end
                8'hFF: begin quad_n = 1'b0; state_n = SKIP; end
                default: state_n = SKIP;
              endcase
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            shreg_n = shift_nib[19:0];
            cnt_n   = cnt + 8'd1;
            if (cnt == 8'd5) begin
              cnt_n  = 8'd0;
              half_n = 1'b0;
              addr_n = shift_nib[ADDRESS_WIDTH-1:0];
              if (is_write) begin
                state_n = WRITE;
              end else if (DUMMY_NIBBLES == 0) begin
                rd_byte_n = mem[shift_nib[ADDRESS_WIDTH-1:0]];
                state_n   = READ;
              end else begin
                state_n = DUMMY;
              end
            end
          end
        end
        DUMMY: begin
          if (sck_rise) begin
            cnt_n = cnt + 8'd1;
            if (cnt == 8'(DUMMY_NIBBLES - 1)) begin
              cnt_n     = 8'd0;
              rd_byte_n = mem[addr];
              state_n   = READ;
            end
          end
        end
        READ: begin
          // Drive on sck fall so the nibble is settled well before the initiator's next rise.
          if (sck_fall) begin
            sio_oe_n = 1'b1;
            if (!half) begin
              sio_o_n = rd_byte[7:4];
              half_n  = 1'b1;
            end else begin
              sio_o_n   = rd_byte[3:0];
              half_n    = 1'b0;
              addr_n    = addr_inc;
              rd_byte_n = mem[addr_inc];
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            if (!half) begin
              wr_hi_n = sio_in;
              half_n  = 1'b1;
            end else begin
              mem_we = 1'b1;
              addr_n = addr_inc;
              half_n = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers; reset clears everything except memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q     <= 1'b0;
      cnt       <= 8'd0;
      shreg     <= 20'd0;
      addr      <= '0;
      is_write  <= 1'b0;
      half      <= 1'b0;
      wr_hi     <= 4'd0;
      rd_byte   <= 8'd0;
      quad_mode <= 1'b0;
      sio_oe    <= 1'b0;
      sio_o     <= 4'd0;
    end else begin
      sck_q     <= sram.sram_sck;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      addr      <= addr_n;
      is_write  <= is_write_n;
      half      <= half_n;
      wr_hi     <= wr_hi_n;
      rd_byte   <= rd_byte_n;
      quad_mode <= quad_n;
      sio_oe    <= sio_oe_n;
      sio_o     <= sio_o_n;
    end
  end

  // Byte storage; no reset so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= mem_wdata;
  end

endmodule

// File: tb/tb_qspi_sram_responder.sv
// tb/tb_qspi_sram_responder.sv - randomized self-checking bench for qspi_sram_responder
module tb_qspi_sram_responder;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int DUMMY = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic quad_mode;

  qspi_sram_responder_if sram ();

  qspi_sram_responder #(.ADDRESS_WIDTH(AW), .DUMMY_NIBBLES(DUMMY)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sram      (sram),
    .quad_mode (quad_mode)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_mem [DEPTH];
  bit model_quad = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] o, output logic oe);
    {sram.sram_sio3_i, sram.sram_sio2_i, sram.sram_sio1_i, sram.sram_sio0_i} = nib;
    sram.sram_sck = 1'b1;
    repeat (2) @(negedge clk);
    sram.sram_sck = 1'b0;
    repeat (2) @(negedge clk);
    o  = {sram.sram_sio3_o, sram.sram_sio2_o, sram.sram_sio1_o, sram.sram_sio0_o};
    oe = sram.sram_sio_oe;
  endtask

  task automatic cs_begin();
    sram.sram_cs_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_end();
    sram.sram_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("deselect_oe", sram.sram_sio_oe, 1'b0);
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    logic [3:0] o;
    logic oe;
    cs_begin();
    for (int i = 7; i >= 0; i--) begin
      sck_cycle({3'b000, b[i]}, o, oe);
      check("spi_oe", oe, 1'b0);
    end
    cs_end();
    if (!model_quad && b == 8'h38) model_quad = 1'b1;
    check("spi_quad_mode", quad_mode, model_quad);
  endtask

  task automatic quad_cmd(input logic [7:0] b);
    logic [3:0] o;
    logic oe;
    cs_begin();
    sck_cycle(b[7:4], o, oe);
    sck_cycle(b[3:0], o, oe);
    cs_end();
    if (model_quad && b == 8'hFF) model_quad = 1'b0;
    check("quad_cmd_mode", quad_mode, model_quad);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [3:0] o;
    logic oe;
    sck_cycle(cmd[7:4], o, oe);
    sck_cycle(cmd[3:0], o, oe);
    for (int i = 5; i >= 0; i--) begin
      sck_cycle(a[i*4 +: 4], o, oe);
      check("hdr_oe", oe, 1'b0);
    end
  endtask

  task automatic quad_write(input logic [23:0] a, input logic [3:0] nibs[$]);
    logic [3:0] o;
    logic oe;
    int base;
    cs_begin();
    send_hdr(8'h02, a);
    foreach (nibs[i]) begin
      sck_cycle(nibs[i], o, oe);
      check("wr_oe", oe, 1'b0);
    end
    cs_end();
    base = int'(a) % DEPTH;
    if (model_quad)
      for (int k = 0; k + 1 < nibs.size(); k += 2)
        model_mem[(base + k / 2) % DEPTH] = {nibs[k], nibs[k+1]};
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [7:0] data[$]);
    logic [3:0] nibs[$];
    foreach (data[i]) begin
      nibs.push_back(data[i][7:4]);
      nibs.push_back(data[i][3:0]);
    end
    quad_write(a, nibs);
  endtask

  task automatic quad_read(input logic [23:0] a, input int n, input string tag);
    logic [3:0] o;
    logic oe;
    logic [7:0] exp_byte;
    int base;
    base = int'(a) % DEPTH;
    cs_begin();
    send_hdr(8'h03, a);
    for (int d = 0; d < DUMMY - 1; d++) begin
      sck_cycle(4'($urandom_range(0, 15)), o, oe);
      check("dummy_oe", oe, 1'b0);
    end
    for (int k = 0; k < 2 * n; k++) begin
      sck_cycle(4'($urandom_range(0, 15)), o, oe);
      exp_byte = model_mem[(base + k / 2) % DEPTH];
      if (model_quad) begin
        check({tag, "_oe"}, oe, 1'b1);
        check({tag, "_nib"}, o, (k % 2 == 0) ? exp_byte[7:4] : exp_byte[3:0]);
      end else begin
        check({tag, "_ignored_oe"}, oe, 1'b0);
      end
    end
    cs_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] o;
    logic oe;
    logic [7:0] bytes[$];
    logic [3:0] nibs[$];
    logic [23:0] a;
    int n;

    sram.sram_cs_n = 1'b1;
    sram.sram_sck  = 1'b0;
    {sram.sram_sio3_i, sram.sram_sio2_i, sram.sram_sio1_i, sram.sram_sio0_i} = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_quad", quad_mode, 1'b0);
    check("rst_oe", sram.sram_sio_oe, 1'b0);
    check("rst_sio", {sram.sram_sio3_o, sram.sram_sio2_o, sram.sram_sio1_o, sram.sram_sio0_o}, 4'h0);

    // A quad read in SPI mode must be ignored
    quad_read(24'h000010, 2, "spi_ignore");

    // Mode switching
    spi_cmd(8'h38);
    quad_cmd(8'hFF);
    spi_cmd(8'h38);

    // Basic write/read
    bytes = {8'hAB, 8'hCD};
    write_bytes(24'h000010, bytes);
    quad_read(24'h000010, 2, "basic");

    // Address wrap and aliasing
    bytes = {8'h12, 8'h34};
    write_bytes(24'h000FFF, bytes);
    quad_read(24'h000000, 1, "wrap_lo");
    quad_read(24'h000FFF, 1, "wrap_hi");
    quad_read(24'h001FFF, 2, "alias");

    // Abort mid-byte: trailing odd nibble is dropped
    bytes = {8'h00, 8'h00};
    write_bytes(24'h000020, bytes);
    nibs = {4'h5, 4'h6, 4'h7};
    quad_write(24'h000020, nibs);
    check("abort_model_20", model_mem[12'h020], 8'h56);
    quad_read(24'h000020, 2, "abort");

    // Randomized write/read traffic, upper address bits randomized
    for (int it = 0; it < 24; it++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      bytes.delete();
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
      write_bytes(a, bytes);
      a[23:AW] = (24 - AW)'($urandom);
      quad_read(a, n, "rand");
    end

    // Reset during the read data phase
    cs_begin();
    send_hdr(8'h03, 24'h000010);
    for (int d = 0; d < DUMMY; d++) sck_cycle(4'h0, o, oe);
    check("midread_oe_before", oe, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midread_rst_oe", sram.sram_sio_oe, 1'b0);
    check("midread_rst_quad", quad_mode, 1'b0);
    model_quad = 1'b0;
    sram.sram_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    quad_read(24'h000010, 2, "post_rst_ignore");
    spi_cmd(8'h38);
    quad_read(24'h000010, 2, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
